// File: rtl/heartbeat_capture_ctrl.sv
`timescale 1ns/1ps
// heartbeat_capture_ctrl
//   Sequences one DEPTH-sample heartbeat frame through an external buffer:
//   clear the buffer, arm, capture DEPTH ADC samples after a beat trigger,
//   arbitrate round-robin between two readout consumers and replay the frame
//   to the grantee, then clear again.
// Ports
//   clock, reset              : system clock, asynchronous active-low reset
//   adc_valid, adc_data       : incoming sample strobe and value
//   trigger                   : beat-detect pulse, honoured only when armed
//   req[1:0] / gnt[1:0]       : consumer requests (0=display, 1=UART) / one-hot grant
//   buf_reset_n, buf_sample,
//   buf_data, buf_read        : controls toward the heartbeat buffer
//   buf_full, buf_dataout     : status and registered read data from the buffer
//   out_valid/out_data/out_last : replayed frame toward the granted consumer
//   busy                      : low only while armed
//   drop_count                : saturating count of samples seen outside capture
module heartbeat_capture_ctrl #(
    parameter int DEPTH = 100,
    parameter int DW    = 16,
    parameter int IW    = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    input  logic          trigger,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic          buf_reset_n,
    output logic          buf_sample,
    output logic [DW-1:0] buf_data,
    output logic          buf_read,
    input  logic          buf_full,
    input  logic [DW-1:0] buf_dataout,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic [7:0]    drop_count
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_ARMED,
        S_FILL,
        S_ARB,
        S_READ
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] wcount_q, wcount_d;
    logic [IW-1:0] rcount_q, rcount_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          rr_q, rr_d;
    logic          buf_read_q, buf_read_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [7:0]    drop_q, drop_d;
    logic          sample;
    logic          grant_idx;

    always_comb begin
        state_d     = state_q;
        wcount_d    = wcount_q;
        rcount_d    = rcount_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        buf_read_d  = 1'b0;
        grant_idx   = 1'b0;
        // The buffer registers its read data, so the beat trails the read by one cycle.
        out_valid_d = buf_read_q;
        out_last_d  = buf_read_q && (rcount_q == LAST_IDX);
        drop_d      = drop_q;

        // buf_full can only rise once DEPTH samples are in, by which time FILL
        // has already been left; gating on it is a guard against overfill.
        sample = (state_q == S_FILL) && adc_valid && !buf_full;

        if (adc_valid && (state_q != S_FILL) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            S_CLEAR: begin
                wcount_d = '0;
                rcount_d = '0;
                state_d  = S_ARMED;
            end
            S_ARMED: begin
                if (trigger) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (sample) begin
                    wcount_d = wcount_q + 1'b1;
                    if (wcount_q == LAST_IDX) begin
                        state_d = S_ARB;
                    end
                end
            end
            S_ARB: begin
                if (req != 2'b00) begin
                    // rr_q holds the index that wins the next tie.
                    grant_idx  = (req == 2'b11) ? rr_q : req[1];
                    gnt_d      = grant_idx ? 2'b10 : 2'b01;
                    rr_d       = ~grant_idx;
                    buf_read_d = 1'b1;
                    rcount_d   = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (buf_read_q) begin
                    rcount_d   = rcount_q + 1'b1;
                    buf_read_d = (rcount_q != LAST_IDX);
                end else begin
                    // Reads are done and the final beat is on the output this cycle.
                    gnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CLEAR;
            wcount_q    <= '0;
            rcount_q    <= '0;
            gnt_q       <= '0;
            rr_q        <= 1'b0;
            buf_read_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            wcount_q    <= wcount_d;
            rcount_q    <= rcount_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            buf_read_q  <= buf_read_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            drop_q      <= drop_d;
        end
    end

    assign gnt         = gnt_q;
    assign buf_reset_n = (state_q != S_CLEAR);
    assign buf_sample  = sample;
    assign buf_data    = (state_q == S_FILL) ? adc_data : '0;
    assign buf_read    = buf_read_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_valid_q ? buf_dataout : '0;
    assign out_last    = out_last_q;
    assign busy        = (state_q != S_ARMED);
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_heartbeat_capture_ctrl.sv
`timescale 1ns/1ps
module tb_heartbeat_capture_ctrl;

    localparam int DEPTH = 100;
    localparam int DW    = 16;
    localparam int IW    = 7;
    localparam int LOGN  = 1024;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          trigger = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [1:0]    gnt;
    logic          buf_reset_n, buf_sample, buf_read, buf_full;
    logic [DW-1:0] buf_data, buf_dataout, out_data;
    logic          out_valid, out_last, busy;
    logic [7:0]    drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    heartbeat_capture_ctrl #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) dut (
        .clock(clock), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
        .trigger(trigger), .req(req), .gnt(gnt), .buf_reset_n(buf_reset_n),
        .buf_sample(buf_sample), .buf_data(buf_data), .buf_read(buf_read),
        .buf_full(buf_full), .buf_dataout(buf_dataout), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .busy(busy), .drop_count(drop_count)
    );

    // Behavioural heartbeat buffer: write pointer, full flag, registered read data.
    logic [DW-1:0] mem [DEPTH];
    int            wptr, rptr;
    logic [DW-1:0] dout_r;
    assign buf_full    = (wptr == DEPTH);
    assign buf_dataout = dout_r;

    always @(posedge clock or negedge buf_reset_n) begin
        if (!buf_reset_n) begin
            wptr   <= 0;
            rptr   <= 0;
            dout_r <= '0;
        end else begin
            if (buf_sample && wptr < DEPTH) begin
                mem[wptr] <= buf_data;
                wptr      <= wptr + 1;
            end
            if (buf_read) begin
                dout_r <= mem[rptr];
                rptr   <= (rptr == DEPTH - 1) ? 0 : rptr + 1;
            end
        end
    end

    // Monitor: monotonic totals and logs, sampled mid-cycle.
    logic [DW-1:0] data_log [LOGN];
    logic [1:0]    gnt_log  [LOGN];
    int     tot_beats = 0, last_pos = -1, bursts = 0, n_samp = 0, n_clr = 0, viol = 0;
    longint cyc = 0, gnt_rise_cyc = -1, last_cyc = -1;
    logic   prev_ov = 1'b0;
    logic [1:0] prev_gnt = 2'b00;

    always @(negedge clock) begin
        cyc++;
        if (buf_sample) n_samp++;
        if (buf_sample && buf_full) viol++;
        if (buf_sample && buf_read) viol++;
        if (out_last && !out_valid) viol++;
        if (reset && !buf_reset_n) n_clr++;
        if (gnt != 2'b00 && prev_gnt == 2'b00) gnt_rise_cyc = cyc;
        if (out_valid) begin
            if (!prev_ov) bursts++;
            data_log[tot_beats % LOGN] = out_data;
            gnt_log[tot_beats % LOGN]  = gnt;
            if (out_last) begin
                last_pos = tot_beats;
                last_cyc = cyc;
            end
            tot_beats++;
        end
        prev_ov  = out_valid;
        prev_gnt = gnt;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_armed(input string nm);
        int k;
        k = 0;
        @(posedge clock); #1;
        while (busy !== 1'b0 && k < 1000) begin
            @(posedge clock); #1;
            k++;
        end
        chk({nm, "_armed_wait"}, longint'(busy), 0);
    endtask

    // Entered at posedge+1 while armed; the first sample lands in the first FILL cycle.
    task automatic fill_frame(input int base, input int gap, input int extra, input bit noise);
        trigger = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clock); #1;
            trigger   = noise && (i == 50);
            adc_valid = 1'b1;
            adc_data  = DW'(base + i);
            for (int g = 0; g < gap; g++) begin
                @(posedge clock); #1;
                adc_valid = 1'b0;
                trigger   = 1'b0;
            end
        end
        for (int e = 0; e < extra; e++) begin
            @(posedge clock); #1;
            adc_valid = 1'b1;
            adc_data  = '1;
        end
        @(posedge clock); #1;
        adc_valid = 1'b0;
        trigger   = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [1:0] req;
        int         base;
        int         gap;
        int         extra;
        bit         noise;
        logic [1:0] exp_gnt;
        int         exp_drop;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int b0, s0, bu0, v0, c0, k, derr, gerr;
        wait_armed(v.name);
        b0 = tot_beats; s0 = n_samp; bu0 = bursts; v0 = viol; c0 = n_clr;
        req = v.req;
        fill_frame(v.base, v.gap, v.extra, v.noise);
        k = 0;
        while (tot_beats - b0 < DEPTH && k < 600) begin
            @(posedge clock); #1;
            trigger = v.noise && (k == 40);
            if (v.noise && k == 40) req = 2'b00;
            k++;
        end
        trigger = 1'b0;
        @(negedge clock);
        chk({v.name, "_gnt_after"}, longint'(gnt), 0);
        chk({v.name, "_beats"}, tot_beats - b0, DEPTH);
        derr = 0; gerr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (data_log[(b0 + i) % LOGN] !== DW'(v.base + i)) derr++;
            if (gnt_log[(b0 + i) % LOGN] !== v.exp_gnt) gerr++;
        end
        chk({v.name, "_data_errs"}, derr, 0);
        chk({v.name, "_gnt_errs"}, gerr, 0);
        chk({v.name, "_last_pos"}, last_pos - b0, DEPTH - 1);
        chk({v.name, "_bursts"}, bursts - bu0, 1);
        chk({v.name, "_latency"}, last_cyc - gnt_rise_cyc, DEPTH);
        chk({v.name, "_samples"}, n_samp - s0, DEPTH);
        chk({v.name, "_drop"}, longint'(drop_count), v.exp_drop);
        chk({v.name, "_viol"}, viol - v0, 0);
        wait_armed(v.name);
        chk({v.name, "_clear_cycles"}, n_clr - c0, 1);
    endtask

    vec_t tbl[5];

    initial begin
        int k, s0, b0;

        tbl[0] = '{"tie1_slow",  2'b11,   0, 3, 0, 1'b0, 2'b01, 0};
        tbl[1] = '{"tie2",       2'b11, 300, 1, 0, 1'b0, 2'b10, 0};
        tbl[2] = '{"tie3_extra", 2'b11, 500, 0, 5, 1'b0, 2'b01, 5};
        tbl[3] = '{"noise_uart", 2'b10, 700, 2, 0, 1'b1, 2'b10, 5};
        tbl[4] = '{"disp",       2'b01, 900, 0, 0, 1'b0, 2'b01, 5};

        // Reset state
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_ctrl", {gnt, buf_reset_n, buf_sample, buf_read, out_valid, out_last, busy}, 7'b0000001);
        chk("rst_data", {out_data, buf_data, drop_count}, 0);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("clear_cycle", {buf_reset_n, busy}, 2'b01);
        @(negedge clock);
        chk("armed_cycle", {buf_reset_n, busy}, 2'b10);

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // Asynchronous reset at readout beat 40, then a clean frame 200..299.
        wait_armed("abort");
        b0 = tot_beats;
        req = 2'b01;
        fill_frame(4000, 0, 0, 1'b0);
        k = 0;
        while (tot_beats - b0 < 40 && k < 300) begin
            @(posedge clock); #1;
            k++;
        end
        chk("abort_reached_beat40", tot_beats - b0, 40);
        reset = 1'b0;
        #1;
        chk("abort_ctrl", {gnt, buf_reset_n, buf_sample, buf_read, out_valid, out_last, busy}, 7'b0000001);
        chk("abort_data", {out_data, buf_data, drop_count}, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        req = 2'b00;
        run_frame('{"after_abort", 2'b01, 200, 0, 0, 1'b0, 2'b01, 0});

        // Samples while armed with no trigger: all dropped, counter saturates.
        wait_armed("sat");
        s0 = n_samp;
        for (int i = 0; i < 300; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(i);
            @(posedge clock); #1;
        end
        adc_valid = 1'b0;
        @(negedge clock);
        chk("sat_drop", longint'(drop_count), 255);
        chk("sat_samples", n_samp - s0, 0);
        chk("sat_still_armed", longint'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
